alu_65xx: RTL and testbench
===========================

ALU_65XX -- requirements
Module: alu_65xx

Interface
REQ-001 SHALL take parameter WIDTH, default 8, operand/result width; multiple of 4, range 8..32.
REQ-002 SHALL have port clk  input  1  sole clock; all state updates on rising edge.
REQ-003 SHALL have port rst  input  1  reset, synchronous, active-high.
REQ-004 SHALL have port RDY  input  1  global enable; low freezes all state, FSM and outputs.
REQ-005 SHALL have port op  input  4  operation: 0011 AI+BI, 0111 AI-BI, 1011 AI+AI, 1100 AI|BI, 1101 AI&BI, 1110 AI^BI, 1111 AI.
REQ-006 SHALL have port right  input  1  right-shift select, applied to the logic stage.
REQ-007 SHALL have ports AI and BI  input  WIDTH  operands.
REQ-008 SHALL have port CI  input  1  carry in, also the shift-in bit.
REQ-009 SHALL have port BCD  input  1  BCD-style carry on every nibble.
REQ-010 SHALL have port mul_start  input  1  request unsigned AI*BI.
REQ-011 SHALL have port OUT  output  WIDTH  registered result, or product low half.
REQ-012 SHALL have ports CO, N, HC  output  1 each  registered carry, sign and nibble-0 carry.
REQ-013 SHALL have ports V, Z  output  1 each  overflow and zero, derived from registered state.
REQ-014 SHALL have port MHI  output  WIDTH  product high half.
REQ-015 SHALL have port busy  output  1  multiply in progress.
REQ-016 SHALL have port mul_done  output  1  one-cycle pulse when a product is valid.

Function
REQ-017 Single-cycle op SHALL be captured on the edge where RDY=1 and the FSM is IDLE (mul_start=0); results visible the next cycle.
REQ-018 Logic stage SHALL be: op[1:0] 00 OR, 01 AND, 10 XOR, 11 AI; when right=1, the logic result SHALL be {AI[0], CI, AI[WIDTH-1:1]}.
REQ-019 Adder B operand SHALL be: op[3:2] 00 BI, 01 ~BI, 10 logic result, 11 zero.
REQ-020 Adder carry-in SHALL be 0 when right=1 or op[3:2]=11, otherwise CI.
REQ-021 Addition SHALL run nibble by nibble; carry into nibble k+1 = binary carry of nibble k OR (BCD AND sum_k[3:1]>=5).
REQ-022 Final carry SHALL use the same rule, so CO = top nibble carry OR BCD adjust carry; no decimal correction is applied to OUT.
REQ-023 HC SHALL be the carry out of nibble 0; N SHALL be OUT[WIDTH-1].
REQ-024 V SHALL be AI_msb ^ Badd_msb ^ CO ^ N, using MSBs registered with the result.
REQ-025 Z SHALL be the NOR of OUT.
REQ-026 FSM states SHALL be IDLE and MUL.
REQ-027 IDLE->MUL SHALL occur on RDY=1 and mul_start=1: capture AI, BI, clear the accumulator, count=WIDTH, busy=1.
REQ-028 In MUL, each RDY=1 edge SHALL perform one shift-add step (LSB-first) and decrement count.
REQ-029 On the step where count reaches 0: OUT=product[WIDTH-1:0], MHI=product[2W-1:W], N=product MSB, CO=0, HC=0, V=0, Z=(product==0), mul_done=1 for one cycle, state->IDLE.
REQ-030 Latency SHALL be exactly WIDTH RDY-qualified edges from the start edge to the done edge.
REQ-031 While busy, mul_start and ALU ops SHALL be ignored; OUT/flags hold their pre-start values until done.
REQ-032 A new op or mul_start on the cycle mul_done is high SHALL be accepted normally (state is IDLE).
REQ-033 MHI SHALL hold until the next multiply completes and be unaffected by ALU ops.

Reset
REQ-034 On rst=1 at a clock edge, regardless of RDY: state=IDLE, busy=0, mul_done=0, OUT=0, MHI=0, CO=0, N=0, HC=0, and MSB registers 0 (so V=0, Z=1).
REQ-035 Reset mid-multiply SHALL abort the multiply with no mul_done pulse.

Structure
REQ-036 The op encodings and FSM state enum SHALL live in package alu_65xx_pkg.
REQ-037 Nibble add with BCD carry SHALL be one sub-module, bcd_nibble_add, instantiated WIDTH/4 times in a chain.

Verification
REQ-038 WIDTH=8, op=0011, AI=0x45, BI=0x38, CI=0, BCD=1 -> OUT=0x8D, HC=1, CO=0.
REQ-039 WIDTH=8, op=0011, AI=0x7F, BI=0x01, BCD=0 -> OUT=0x80, N=1, V=1, CO=0, Z=0.
REQ-040 WIDTH=16, op=0011, AI=0x9999, BI=0x0001, BCD=1 -> OUT=0xAAAA, CO=1, HC=1.
REQ-041 WIDTH=8, op=1111, right=1, AI=0x81, CI=1 -> OUT=0xC0, CO=1, N=1.
REQ-042 WIDTH=8, mul_start with AI=0xFF, BI=0xFF -> mul_done exactly 8 edges later, MHI=0xFE, OUT=0x01; RDY=0 for 3 cycles mid-run delays mul_done by 3.
REQ-043 rst asserted at step 4 of a multiply -> busy=0 next cycle, no mul_done pulse, OUT=0, Z=1.

Source files
------------

// File: rtl/alu_65xx_pkg.sv
// Shared encodings for the 65xx-style ALU: opcodes, operand selects and FSM states.
package alu_65xx_pkg;

    localparam logic [3:0] OP_ADD  = 4'b0011;
    localparam logic [3:0] OP_SUB  = 4'b0111;
    localparam logic [3:0] OP_DBL  = 4'b1011;
    localparam logic [3:0] OP_OR   = 4'b1100;
    localparam logic [3:0] OP_AND  = 4'b1101;
    localparam logic [3:0] OP_XOR  = 4'b1110;
    localparam logic [3:0] OP_PASS = 4'b1111;

    // op[1:0]: logic stage function
    localparam logic [1:0] LOG_OR  = 2'b00;
    localparam logic [1:0] LOG_AND = 2'b01;
    localparam logic [1:0] LOG_XOR = 2'b10;
    localparam logic [1:0] LOG_A   = 2'b11;

    // op[3:2]: adder B operand source
    localparam logic [1:0] BSEL_B    = 2'b00;
    localparam logic [1:0] BSEL_NB   = 2'b01;
    localparam logic [1:0] BSEL_LOG  = 2'b10;
    localparam logic [1:0] BSEL_ZERO = 2'b11;

    typedef enum logic {
        IDLE = 1'b0,
        MUL  = 1'b1
    } state_e;

endpackage

// File: rtl/alu_65xx_bcd_nibble_add.sv
// One 4-bit adder slice; carry out is also forced when BCD mode sees a sum of 10 or more.
module bcd_nibble_add (
    input  logic [3:0] a,
    input  logic [3:0] b,
    input  logic       ci,
    input  logic       bcd,
    output logic [3:0] sum_c,
    output logic       co_c
);

    logic [4:0] raw;

    assign raw   = 5'(a) + 5'(b) + 5'(ci);
    assign sum_c = raw[3:0];
    assign co_c  = raw[4] | (bcd & (raw[3:1] >= 3'd5));

endmodule

// File: rtl/alu_65xx.sv
// 65xx-style ALU with nibble-chained BCD carry and a sequential shift-add multiplier.
module alu_65xx
    import alu_65xx_pkg::*;
#(
    parameter int unsigned WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             RDY,
    input  logic [3:0]       op,
    input  logic             right,
    input  logic [WIDTH-1:0] AI,
    input  logic [WIDTH-1:0] BI,
    input  logic             CI,
    input  logic             BCD,
    input  logic             mul_start,
    output logic [WIDTH-1:0] OUT,
    output logic             CO,
    output logic             N,
    output logic             HC,
    output logic             V,
    output logic             Z,
    output logic [WIDTH-1:0] MHI,
    output logic             busy,
    output logic             mul_done
);

    localparam int unsigned NIB   = WIDTH / 4;
    localparam int unsigned CNT_W = $clog2(WIDTH + 1);

    state_e state_q, state_nxt;

    logic [WIDTH-1:0] logic_res, b_add, sum;
    logic             shift_out, cin, carry_top, carry_nib0;

    logic             a_msb, b_msb, hi_nz;
    logic [WIDTH-1:0] mul_a, mul_hi, mul_lo;
    logic [CNT_W-1:0] cnt;

    logic [WIDTH-1:0] out_nxt, mhi_nxt, mul_a_nxt, mul_hi_nxt, mul_lo_nxt;
    logic             co_nxt, n_nxt, hc_nxt, a_msb_nxt, b_msb_nxt, hi_nz_nxt;
    logic             busy_nxt, done_nxt;
    logic [CNT_W-1:0] cnt_nxt;

    logic [WIDTH:0]   step_sum;
    logic [WIDTH-1:0] step_hi, step_lo;

    // Logic stage; a right shift replaces the selected function and pushes AI[0] out
    always_comb begin
        logic_res = AI;
        shift_out = 1'b0;
        if (right) begin
            logic_res = {CI, AI[WIDTH-1:1]};
            shift_out = AI[0];
        end else begin
            case (op[1:0])
                LOG_OR:  logic_res = AI | BI;
                LOG_AND: logic_res = AI & BI;
                LOG_XOR: logic_res = AI ^ BI;
                default: logic_res = AI;
            endcase
        end
    end

    always_comb begin
        case (op[3:2])
            BSEL_B:   b_add = BI;
            BSEL_NB:  b_add = ~BI;
            BSEL_LOG: b_add = logic_res;
            default:  b_add = '0;
        endcase
        cin = (right || (op[3:2] == BSEL_ZERO)) ? 1'b0 : CI;
    end

    // Ripple chain of nibble adders; each stage keeps its own carry net
    for (genvar k = 0; k < NIB; k++) begin : g_nib
        logic ci_k, co_k;
        if (k == 0) begin : g_first
            assign ci_k = cin;
        end else begin : g_rest
            assign ci_k = g_nib[k-1].co_k;
        end
        bcd_nibble_add u_nib (
            .a     (logic_res[4*k +: 4]),
            .b     (b_add[4*k +: 4]),
            .ci    (ci_k),
            .bcd   (BCD),
            .sum_c (sum[4*k +: 4]),
            .co_c  (co_k)
        );
    end

    assign carry_top  = g_nib[NIB-1].co_k;
    assign carry_nib0 = g_nib[0].co_k;

    // One LSB-first shift-add step of the multiplier
    assign step_sum = {1'b0, mul_hi} + (mul_lo[0] ? {1'b0, mul_a} : '0);
    assign step_hi  = step_sum[WIDTH:1];
    assign step_lo  = {step_sum[0], mul_lo[WIDTH-1:1]};

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
        end else if (RDY) begin
            state_q <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state_q;
        case (state_q)
            IDLE:    if (mul_start) state_nxt = MUL;
            MUL:     if (cnt == CNT_W'(1)) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        out_nxt    = OUT;
        mhi_nxt    = MHI;
        co_nxt     = CO;
        n_nxt      = N;
        hc_nxt     = HC;
        a_msb_nxt  = a_msb;
        b_msb_nxt  = b_msb;
        hi_nz_nxt  = hi_nz;
        mul_a_nxt  = mul_a;
        mul_hi_nxt = mul_hi;
        mul_lo_nxt = mul_lo;
        cnt_nxt    = cnt;
        done_nxt   = 1'b0;
        busy_nxt   = (state_nxt == MUL);
        case (state_q)
            IDLE: begin
                if (mul_start) begin
                    mul_a_nxt  = AI;
                    mul_hi_nxt = '0;
                    mul_lo_nxt = BI;
                    cnt_nxt    = CNT_W'(WIDTH);
                end else begin
                    out_nxt   = sum;
                    co_nxt    = carry_top | shift_out;
                    hc_nxt    = carry_nib0;
                    n_nxt     = sum[WIDTH-1];
                    a_msb_nxt = AI[WIDTH-1];
                    b_msb_nxt = b_add[WIDTH-1];
                    hi_nz_nxt = 1'b0;
                end
            end
            MUL: begin
                mul_hi_nxt = step_hi;
                mul_lo_nxt = step_lo;
                cnt_nxt    = cnt - CNT_W'(1);
                if (cnt == CNT_W'(1)) begin
                    // b_msb mirrors N so the V equation evaluates to zero
                    out_nxt   = step_lo;
                    mhi_nxt   = step_hi;
                    n_nxt     = step_hi[WIDTH-1];
                    co_nxt    = 1'b0;
                    hc_nxt    = 1'b0;
                    a_msb_nxt = 1'b0;
                    b_msb_nxt = step_hi[WIDTH-1];
                    hi_nz_nxt = |step_hi;
                    done_nxt  = 1'b1;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            OUT      <= '0;
            MHI      <= '0;
            CO       <= 1'b0;
            N        <= 1'b0;
            HC       <= 1'b0;
            a_msb    <= 1'b0;
            b_msb    <= 1'b0;
            hi_nz    <= 1'b0;
            mul_a    <= '0;
            mul_hi   <= '0;
            mul_lo   <= '0;
            cnt      <= '0;
            busy     <= 1'b0;
            mul_done <= 1'b0;
        end else if (RDY) begin
            OUT      <= out_nxt;
            MHI      <= mhi_nxt;
            CO       <= co_nxt;
            N        <= n_nxt;
            HC       <= hc_nxt;
            a_msb    <= a_msb_nxt;
            b_msb    <= b_msb_nxt;
            hi_nz    <= hi_nz_nxt;
            mul_a    <= mul_a_nxt;
            mul_hi   <= mul_hi_nxt;
            mul_lo   <= mul_lo_nxt;
            cnt      <= cnt_nxt;
            busy     <= busy_nxt;
            mul_done <= done_nxt;
        end
    end

    assign V = a_msb ^ b_msb ^ CO ^ N;
    // A multiply result is zero only if the high half is zero too
    assign Z = ~(|OUT) & ~hi_nz;

endmodule

// File: tb/tb_alu_65xx.sv
// Self-checking bench for alu_65xx: 8-bit and 16-bit instances against an arithmetic reference model.
module tb_alu_65xx;
    import alu_65xx_pkg::*;

    typedef struct packed {
        logic [31:0] out;
        logic        co;
        logic        n;
        logic        hc;
        logic        v;
        logic        z;
    } res_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst, rdy, right, ci, bcd, mul_start, mul_start16;
    logic [3:0]  op;
    logic [7:0]  ai8, bi8, out8, mhi8;
    logic [15:0] ai16, bi16, out16, mhi16;
    logic        co8, n8, hc8, v8, z8, busy8, done8;
    logic        co16, n16, hc16, v16, z16, busy16, done16;

    int   tests = 0;
    int   failed = 0;
    res_t last8;
    logic [7:0] mhi_exp;
    logic [3:0] ops [7];

    alu_65xx #(.WIDTH(8)) u_dut8 (
        .clk(clk), .rst(rst), .RDY(rdy), .op(op), .right(right), .AI(ai8), .BI(bi8),
        .CI(ci), .BCD(bcd), .mul_start(mul_start), .OUT(out8), .CO(co8), .N(n8), .HC(hc8),
        .V(v8), .Z(z8), .MHI(mhi8), .busy(busy8), .mul_done(done8)
    );

    alu_65xx #(.WIDTH(16)) u_dut16 (
        .clk(clk), .rst(rst), .RDY(rdy), .op(op), .right(right), .AI(ai16), .BI(bi16),
        .CI(ci), .BCD(bcd), .mul_start(mul_start16), .OUT(out16), .CO(co16), .N(n16), .HC(hc16),
        .V(v16), .Z(z16), .MHI(mhi16), .busy(busy16), .mul_done(done16)
    );

    // Reference: nibble-wise addition with the decimal carry rule, from the operation definitions
    function automatic res_t ref_alu(input int w, input logic [3:0] o, input logic r,
                                     input logic c_in, input logic b_cd,
                                     input logic [31:0] a, input logic [31:0] b);
        res_t res;
        longint unsigned mask, lg, bv, s;
        logic c, sh;
        mask = (64'd1 << w) - 64'd1;
        sh = 1'b0;
        case (o[1:0])
            2'd0:    lg = 64'(a | b);
            2'd1:    lg = 64'(a & b);
            2'd2:    lg = 64'(a ^ b);
            default: lg = 64'(a);
        endcase
        if (r) begin
            lg = (64'(a) >> 1) | (64'(c_in) << (w - 1));
            sh = a[0];
        end
        case (o[3:2])
            2'd0:    bv = 64'(b);
            2'd1:    bv = 64'(~b) & mask;
            2'd2:    bv = lg;
            default: bv = 64'd0;
        endcase
        c = (r || o[3:2] == 2'd3) ? 1'b0 : c_in;
        res = '0;
        for (int k = 0; k < w / 4; k++) begin
            s = ((lg >> (4 * k)) & 64'd15) + ((bv >> (4 * k)) & 64'd15) + 64'(c);
            res.out = res.out | 32'((s & 64'd15) << (4 * k));
            c = (s >= 64'd16) || (b_cd && ((s & 64'd15) >= 64'd10));
            if (k == 0) res.hc = c;
        end
        res.co = c | sh;
        res.n  = res.out[w-1];
        res.v  = a[w-1] ^ bv[w-1] ^ res.co ^ res.n;
        res.z  = (res.out == 32'd0);
        return res;
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            failed++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic apply(input logic [3:0] o, input logic r, input logic c_in, input logic b_cd,
                         input logic [7:0] a8, input logic [7:0] b8,
                         input logic [15:0] a16, input logic [15:0] b16);
        res_t e8, e16;
        op = o; right = r; ci = c_in; bcd = b_cd;
        ai8 = a8; bi8 = b8; ai16 = a16; bi16 = b16;
        mul_start = 1'b0; rdy = 1'b1;
        step();
        e8  = ref_alu(8, o, r, c_in, b_cd, 32'(a8), 32'(b8));
        e16 = ref_alu(16, o, r, c_in, b_cd, 32'(a16), 32'(b16));
        chk("alu8_out", 32'(out8), e8.out);
        chk("alu8_co", 32'(co8), 32'(e8.co));
        chk("alu8_n", 32'(n8), 32'(e8.n));
        chk("alu8_hc", 32'(hc8), 32'(e8.hc));
        chk("alu8_v", 32'(v8), 32'(e8.v));
        chk("alu8_z", 32'(z8), 32'(e8.z));
        chk("alu8_mhi_hold", 32'(mhi8), 32'(mhi_exp));
        chk("alu8_busy", 32'(busy8), 32'd0);
        chk("alu8_done", 32'(done8), 32'd0);
        chk("alu16_out", 32'(out16), e16.out);
        chk("alu16_co", 32'(co16), 32'(e16.co));
        chk("alu16_n", 32'(n16), 32'(e16.n));
        chk("alu16_hc", 32'(hc16), 32'(e16.hc));
        chk("alu16_v", 32'(v16), 32'(e16.v));
        chk("alu16_z", 32'(z16), 32'(e16.z));
        last8 = e8;
    endtask

    task automatic apply_rand();
        logic [3:0] o;
        o = ($urandom_range(0, 3) == 0) ? 4'($urandom) : ops[$urandom_range(0, 6)];
        apply(o, 1'($urandom), 1'($urandom), 1'($urandom), 8'($urandom), 8'($urandom),
              16'($urandom), 16'($urandom));
    endtask

    // Multiply with optional RDY stall; ends on the cycle mul_done is observed
    task automatic do_mul(input logic [7:0] a, input logic [7:0] b, input int stall);
        logic [15:0] prod;
        int edges, qual;
        logic got, busy_ok, hold_ok, r;
        prod = 16'(a) * 16'(b);
        ai8 = a; bi8 = b; rdy = 1'b1; mul_start = 1'b1;
        step();
        mul_start = 1'b0;
        chk("mul_busy_after_start", 32'(busy8), 32'd1);
        edges = 0; qual = 0; got = 1'b0; busy_ok = 1'b1; hold_ok = 1'b1;
        while (!got && edges < 8 + stall + 8) begin
            r = !(stall > 0 && edges >= 3 && edges < 3 + stall);
            rdy = r;
            op = 4'($urandom); ai8 = 8'($urandom); bi8 = 8'($urandom);
            mul_start = (edges == 1);
            step();
            edges++;
            if (r) qual++;
            if (done8 === 1'b1) begin
                got = 1'b1;
            end else begin
                if (busy8 !== 1'b1) busy_ok = 1'b0;
                if (out8 !== last8.out[7:0] || z8 !== last8.z || v8 !== last8.v ||
                    co8 !== last8.co || n8 !== last8.n || mhi8 !== mhi_exp) hold_ok = 1'b0;
            end
        end
        rdy = 1'b1; mul_start = 1'b0;
        chk("mul_done_seen", 32'(got), 32'd1);
        chk("mul_qual_edges", 32'(qual), 32'd8);
        chk("mul_total_edges", 32'(edges), 32'(8 + stall));
        chk("mul_busy_during", 32'(busy_ok), 32'd1);
        chk("mul_hold_outputs", 32'(hold_ok), 32'd1);
        chk("mul_out", 32'(out8), 32'(prod[7:0]));
        chk("mul_mhi", 32'(mhi8), 32'(prod[15:8]));
        chk("mul_n", 32'(n8), 32'(prod[15]));
        chk("mul_co", 32'(co8), 32'd0);
        chk("mul_hc", 32'(hc8), 32'd0);
        chk("mul_v", 32'(v8), 32'd0);
        chk("mul_z", 32'(z8), 32'(prod == 16'd0));
        chk("mul_busy_at_done", 32'(busy8), 32'd0);
        mhi_exp = prod[15:8];
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: observed no finish, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        logic got;
        ops = '{OP_ADD, OP_SUB, OP_DBL, OP_OR, OP_AND, OP_XOR, OP_PASS};
        mhi_exp = 8'h00;
        rst = 1'b1; rdy = 1'b0; op = OP_ADD; right = 1'b0; ci = 1'b0; bcd = 1'b0;
        mul_start = 1'b0; mul_start16 = 1'b0;
        ai8 = 8'h00; bi8 = 8'h00; ai16 = 16'h0000; bi16 = 16'h0000;
        step();
        step();

        // Reset applies even with RDY low
        chk("rst_out", 32'(out8), 32'd0);
        chk("rst_mhi", 32'(mhi8), 32'd0);
        chk("rst_co", 32'(co8), 32'd0);
        chk("rst_n", 32'(n8), 32'd0);
        chk("rst_hc", 32'(hc8), 32'd0);
        chk("rst_v", 32'(v8), 32'd0);
        chk("rst_z", 32'(z8), 32'd1);
        chk("rst_busy", 32'(busy8), 32'd0);
        chk("rst_done", 32'(done8), 32'd0);
        chk("rst_out16", 32'(out16), 32'd0);
        rst = 1'b0; rdy = 1'b1;

        apply(OP_ADD, 1'b0, 1'b0, 1'b1, 8'h45, 8'h38, 16'h9999, 16'h0001);
        chk("bcd8_out", 32'(out8), 32'h8D);
        chk("bcd8_hc", 32'(hc8), 32'd1);
        chk("bcd8_co", 32'(co8), 32'd0);
        chk("bcd16_out", 32'(out16), 32'hAAAA);
        chk("bcd16_co", 32'(co16), 32'd1);
        chk("bcd16_hc", 32'(hc16), 32'd1);

        apply(OP_ADD, 1'b0, 1'b0, 1'b0, 8'h7F, 8'h01, 16'h7FFF, 16'h0001);
        chk("ovf_out", 32'(out8), 32'h80);
        chk("ovf_n", 32'(n8), 32'd1);
        chk("ovf_v", 32'(v8), 32'd1);
        chk("ovf_co", 32'(co8), 32'd0);
        chk("ovf_z", 32'(z8), 32'd0);

        apply(OP_PASS, 1'b1, 1'b1, 1'b0, 8'h81, 8'h00, 16'h8001, 16'h0000);
        chk("ror_out", 32'(out8), 32'hC0);
        chk("ror_co", 32'(co8), 32'd1);
        chk("ror_n", 32'(n8), 32'd1);

        do_mul(8'hFF, 8'hFF, 0);
        chk("mulff_out", 32'(out8), 32'h01);
        chk("mulff_mhi", 32'(mhi8), 32'hFE);
        apply_rand();
        do_mul(8'hFF, 8'hFF, 3);
        chk("mulff_stall_out", 32'(out8), 32'h01);
        chk("mulff_stall_mhi", 32'(mhi8), 32'hFE);
        apply_rand();
        do_mul(8'h00, 8'h37, 0);
        apply_rand();
        do_mul(8'h10, 8'h10, 0);
        apply_rand();
        for (int i = 0; i < 4; i++) begin
            do_mul(8'($urandom), 8'($urandom), (i == 2) ? 2 : 0);
            apply_rand();
        end

        // RDY low freezes everything, including a start request
        rdy = 1'b0; op = OP_ADD; ai8 = 8'h12; bi8 = 8'h34; mul_start = 1'b1;
        step();
        step();
        chk("frz_out", 32'(out8), last8.out);
        chk("frz_co", 32'(co8), 32'(last8.co));
        chk("frz_z", 32'(z8), 32'(last8.z));
        chk("frz_busy", 32'(busy8), 32'd0);
        chk("frz_mhi", 32'(mhi8), 32'(mhi_exp));
        mul_start = 1'b0; rdy = 1'b1;

        for (int i = 0; i < 40; i++) apply_rand();

        // Reset on the fourth step of a multiply aborts it silently
        ai8 = 8'h5A; bi8 = 8'hC3; mul_start = 1'b1;
        step();
        mul_start = 1'b0;
        repeat (3) step();
        rst = 1'b1;
        step();
        chk("abort_busy", 32'(busy8), 32'd0);
        chk("abort_done", 32'(done8), 32'd0);
        chk("abort_out", 32'(out8), 32'd0);
        chk("abort_z", 32'(z8), 32'd1);
        chk("abort_mhi", 32'(mhi8), 32'd0);
        rst = 1'b0;
        mhi_exp = 8'h00;
        got = 1'b0;
        repeat (12) begin
            step();
            if (done8 === 1'b1) got = 1'b1;
        end
        chk("abort_no_done", 32'(got), 32'd0);
        apply_rand();

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule
